// File: rtl/serial_adder_ctrl.sv
// Bit-serial add/subtract controller: one full adder is reused for every bit
// position, LSB first, with the carry held in a flip-flop between cycles.

module full_adder (
  input  logic i_a,
  input  logic i_b,
  input  logic i_c,
  output logic o_s,
  output logic o_c
);
  assign o_s = i_a ^ i_b ^ i_c;
  assign o_c = (i_a & i_b) | (i_a & i_c) | (i_b & i_c);
endmodule

module serial_adder_ctrl #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic [1:0]       dbg_state
);
  // Handshake: start is a request sampled only while idle (busy=0); requests
  // while busy are dropped. done is a one-cycle pulse with sum/cout valid.

  localparam int CW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           r_state;
  state_t           w_next;
  logic [WIDTH-1:0] r_opa;
  logic [WIDTH-1:0] r_opb;
  logic             r_carry;
  logic [CW-1:0]    r_cnt;
  logic [WIDTH-2:0] r_res;
  logic [WIDTH-1:0] r_sum;
  logic             r_cout;
  logic             w_s;
  logic             w_c;
  logic             w_last;
  logic [WIDTH-1:0] w_full;

  full_adder u_fa (
    .i_a (r_opa[0]),
    .i_b (r_opb[0]),
    .i_c (r_carry),
    .o_s (w_s),
    .o_c (w_c)
  );

  // The newest sum bit enters at the MSB; after WIDTH bits the first one sits at bit 0.
  assign w_full = {w_s, r_res};
  assign w_last = (r_cnt == CW'(WIDTH - 1));

  always_ff @(posedge clk) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_next;
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE:  if (start) w_next = S_RUN;
      S_RUN:   if (w_last) w_next = S_DONE;
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_opa   <= '0;
      r_opb   <= '0;
      r_carry <= 1'b0;
      r_cnt   <= '0;
      r_res   <= '0;
      r_sum   <= '0;
      r_cout  <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_opa   <= a;
            r_opb   <= op ? ~b : b;
            r_carry <= op ? 1'b1 : cin;
            r_cnt   <= '0;
          end
        end
        S_RUN: begin
          r_res   <= w_full[WIDTH-1:1];
          r_carry <= w_c;
          r_opa   <= r_opa >> 1;
          r_opb   <= r_opb >> 1;
          r_cnt   <= r_cnt + 1'b1;
          if (w_last) begin
            r_sum  <= w_full;
            r_cout <= w_c;
          end
        end
        default: ;
      endcase
    end
  end

  assign busy      = (r_state != S_IDLE);
  assign done      = (r_state == S_DONE);
  assign sum       = r_sum;
  assign cout      = r_cout;
  assign dbg_state = r_state;
endmodule

// File: tb/tb_serial_adder_ctrl.sv
// Bench for serial_adder_ctrl: directed cases, back-to-back starts, reset abort
// and a random regression against an arithmetic reference model.

module tb_serial_adder_ctrl;
  localparam int W = 8;

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         op;
  logic [W-1:0] a;
  logic [W-1:0] b;
  logic         cin;
  logic         busy;
  logic         done;
  logic [W-1:0] sum;
  logic         cout;
  logic [1:0]   dbg_state;

  int checks   = 0;
  int failures = 0;

  serial_adder_ctrl #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .op        (op),
    .a         (a),
    .b         (b),
    .cin       (cin),
    .busy      (busy),
    .done      (done),
    .sum       (sum),
    .cout      (cout),
    .dbg_state (dbg_state)
  );

  always #5 clk = ~clk;

  // {cout, sum} from plain arithmetic.
  function automatic logic [W:0] model(input logic m_op, input logic [W-1:0] m_a,
                                       input logic [W-1:0] m_b, input logic m_cin);
    logic [W-1:0] nb;
    nb = ~m_b;
    if (m_op) return {1'b0, m_a} + {1'b0, nb} + (W+1)'(1);
    else      return {1'b0, m_a} + {1'b0, m_b} + (W+1)'(m_cin);
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // One operation: start pulse, scramble inputs during RUN, time and check done.
  task automatic do_op(input string tag, input logic t_op, input logic [W-1:0] t_a,
                       input logic [W-1:0] t_b, input logic t_cin);
    logic [W:0] m;
    int n;
    m = model(t_op, t_a, t_b, t_cin);
    @(negedge clk);
    start = 1'b1; op = t_op; a = t_a; b = t_b; cin = t_cin;
    @(posedge clk); #1;
    start = 1'b0;
    a = W'($urandom); b = W'($urandom); cin = 1'($urandom); op = 1'($urandom);
    check({tag, "_busy_run"}, 32'(busy), 32'd1);
    n = 1;
    while (done !== 1'b1 && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    check({tag, "_done"}, 32'(done), 32'd1);
    check({tag, "_latency"}, 32'(n), 32'(W + 1));
    check({tag, "_sum"}, 32'(sum), 32'(m[W-1:0]));
    check({tag, "_cout"}, 32'(cout), 32'(m[W]));
    @(posedge clk); #1;
    check({tag, "_idle"}, 32'(busy), 32'd0);
    check({tag, "_hold"}, 32'(sum), 32'(m[W-1:0]));
  endtask

  logic [W-1:0] ta [0:39];
  logic [W-1:0] tb_v [0:39];
  logic         top [0:39];
  logic         tcin [0:39];

  initial begin
    logic [W:0] m;
    start = 1'b0; op = 1'b0; a = '0; b = '0; cin = 1'b0;

    // Reset state
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", 32'(busy), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_sum", 32'(sum), 32'd0);
    check("rst_cout", 32'(cout), 32'd0);
    rst = 1'b0;

    // Directed arithmetic cases
    do_op("add_5a_3c", 1'b0, 8'h5A, 8'h3C, 1'b0);
    do_op("add_ff_01", 1'b0, 8'hFF, 8'h01, 1'b0);
    do_op("add_ff_00_cin", 1'b0, 8'hFF, 8'h00, 1'b1);
    do_op("sub_10_20", 1'b1, 8'h10, 8'h20, 1'b0);
    do_op("sub_20_20", 1'b1, 8'h20, 8'h20, 1'b1);

    // start held high with inputs changing every cycle: accepts every W+2 edges
    for (int k = 0; k < 40; k++) begin
      @(negedge clk);
      start = 1'b1;
      op = 1'($urandom); a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      top[k] = op; ta[k] = a; tb_v[k] = b; tcin[k] = cin;
      @(posedge clk); #1;
      check("b2b_done", 32'(done), 32'((k % (W + 2)) == W));
      check("b2b_busy", 32'(busy), 32'((k % (W + 2)) != (W + 1)));
      if ((k % (W + 2)) == W) begin
        m = model(top[k-W], ta[k-W], tb_v[k-W], tcin[k-W]);
        check("b2b_sum", 32'(sum), 32'(m[W-1:0]));
        check("b2b_cout", 32'(cout), 32'(m[W]));
      end
    end
    @(negedge clk);
    start = 1'b0;
    @(posedge clk); #1;

    // Reset four cycles into RUN aborts the operation
    @(negedge clk);
    start = 1'b1; op = 1'b0; a = 8'hC3; b = 8'h5F; cin = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (4) @(posedge clk);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0;
    check("abort_busy", 32'(busy), 32'd0);
    check("abort_done", 32'(done), 32'd0);
    check("abort_sum", 32'(sum), 32'd0);
    check("abort_cout", 32'(cout), 32'd0);
    do_op("after_abort", 1'b1, 8'h07, 8'h09, 1'b0);

    // Random regression
    for (int i = 0; i < 1000; i++) begin
      do_op("rand", 1'($urandom), W'($urandom), W'($urandom), 1'($urandom));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
